phy_rx_sync_ctrl: RTL and testbench
===================================

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment/comma symbol.
REQ-002 Parameter IDLE, default 8'h7C: idle filler symbol, never delivered as data.
REQ-003 Parameter SYNC_COUNT, default 4: consecutive aligned COMMA symbols required to reach ACTIVE; legal range 1..15.
REQ-004 clk_32f  input  1  serial bit clock; all state updates on rising edge.
REQ-005 default_values  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  1  serial line, MSB of each byte first, sampled on every clk_32f rising edge.
REQ-007 active  output  1  high while the FSM is in ACTIVE.
REQ-008 byte_out  output  8  last delivered data byte.
REQ-009 byte_valid  output  1  one-cycle strobe, byte_out/lane_id valid.
REQ-010 lane_id  output  2  destination lane (0..3) of byte_out, for the unstriping datapath.
REQ-011 state_out  output  2  current state, SEARCH=0, LOCK=1, ACTIVE=2; 3 unused.

Function
REQ-012 The block SHALL hold an 8-bit shift register sr; each edge next_sr = {sr[6:0], data_in}.
REQ-013 The block SHALL implement states SEARCH, LOCK, ACTIVE; no other state is reachable.
REQ-014 In SEARCH, next_sr is compared every edge; next_sr == COMMA -> LOCK, bit_cnt = 0, bc_cnt = 1 (bit-granular alignment).
REQ-015 In LOCK/ACTIVE, bit_cnt SHALL increment 0..7 and wrap; the edge where bit_cnt == 7 is a byte boundary and next_sr is the received byte.
REQ-016 LOCK, byte boundary: byte == COMMA -> bc_cnt + 1; if bc_cnt + 1 == SYNC_COUNT -> ACTIVE, lane pointer = 0.
REQ-017 LOCK, byte boundary: byte != COMMA -> SEARCH, bc_cnt = 0.
REQ-018 SYNC_COUNT == 1 SHALL enter ACTIVE directly from SEARCH on the first detected COMMA.
REQ-019 ACTIVE, byte boundary, byte == COMMA: no strobe, lane pointer reset to 0, stay ACTIVE.
REQ-020 ACTIVE, byte boundary, byte == IDLE: no strobe, lane pointer unchanged, stay ACTIVE.
REQ-021 ACTIVE, byte boundary, any other byte: byte_out = byte, lane_id = pointer, byte_valid = 1, pointer = pointer + 1 mod 4 (3 wraps to 0).
REQ-022 byte_valid SHALL be registered at the boundary edge, high for exactly one clk_32f cycle, never high outside ACTIVE.
REQ-023 byte_out and lane_id SHALL hold their value between strobes.
REQ-024 Latency: byte_valid rises on the same edge that samples the byte's 8th (LSB) bit.
REQ-025 ACTIVE is left only by reset; there is no loss-of-sync exit.
REQ-026 active SHALL equal (state == ACTIVE), registered, changing on the boundary edge of the final sync COMMA.

Reset
REQ-027 default_values low SHALL immediately, without a clock, force: state SEARCH, sr 8'h00, bit_cnt 0, bc_cnt 0, pointer 0, active 0, byte_valid 0, byte_out 8'h00, lane_id 0.
REQ-028 Reset asserted mid-byte or mid-strobe SHALL drop byte_valid and active at once; the partial byte is discarded.
REQ-029 After release, the first edge SHALL begin operation in SEARCH with sr = 8'h00; a COMMA is matched only once all 8 of its bits are shifted in.

Verification
REQ-030 Reset pulse, then 4x 8'hBC MSB-first: active rises on the 32nd bit edge; state_out 0->1->2; no byte_valid.
REQ-031 Reset pulse, then 6x BC, then FF,DD,EE,CC,BB,99,AA,88: eight strobes, lane_id 0,1,2,3,0,1,2,3, byte_out matching, each high 1 cycle.
REQ-032 Reset pulse, then 3 garbage bits, then 4x BC: lock on the bit-shifted COMMA; active after BC #4; following 8'h11 delivered on lane 0.
REQ-033 Reset pulse, then BC,BC,8'h55,BC,BC,BC,BC: returns to SEARCH at 8'h55; active only after the final BC.
REQ-034 ACTIVE state; drive FF, 7C, DD, BC, EE: strobes FF/lane0, DD/lane1, EE/lane0; the 7C and BC produce no strobe.
REQ-035 Reset asserted 3 bits into a data byte while ACTIVE: active, byte_valid, and state_out drop to 0 asynchronously; 4x BC after release re-syncs.

Source files
------------

// File: rtl/phy_rx_sync_ctrl.sv
// Serial receive synchroniser: finds the comma at bit granularity, confirms
// byte alignment over SYNC_COUNT consecutive commas, then delivers data bytes
// round-robin across four lanes. Idle and comma bytes are never delivered.
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       default_values,
  input  logic       data_in,
  output logic       active,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] lane_id,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT);

  state_e     state_q;
  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] bc_cnt_q;
  logic [1:0] ptr_q;
  logic       active_q;
  logic       byte_valid_q;
  logic [7:0] byte_out_q;
  logic [1:0] lane_id_q;

  logic [7:0] sr_d;
  logic       boundary;
  logic [3:0] bc_cnt_inc;

  // Next shift-register value and byte-boundary decode
  always_comb begin
    sr_d       = {sr_q[6:0], data_in};
    boundary   = (bit_cnt_q == 3'd7);
    bc_cnt_inc = bc_cnt_q + 4'd1;
  end

  // Alignment FSM with registered outputs
  always_ff @(posedge clk_32f or negedge default_values) begin
    if (!default_values) begin
      state_q      <= SEARCH;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      bc_cnt_q     <= '0;
      ptr_q        <= '0;
      active_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_out_q   <= '0;
      lane_id_q    <= '0;
    end else begin
      sr_q         <= sr_d;
      byte_valid_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          bit_cnt_q <= '0;
          if (sr_d == COMMA) begin
            bc_cnt_q <= 4'd1;
            // A single required comma makes the first detection final.
            if (SYNC_COUNT == 1) begin
              state_q  <= ACTIVE;
              active_q <= 1'b1;
              ptr_q    <= '0;
            end else begin
              state_q <= LOCK;
            end
          end
        end
        LOCK: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (boundary) begin
            if (sr_d == COMMA) begin
              bc_cnt_q <= bc_cnt_inc;
              if (bc_cnt_inc == SYNC_LAST) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
                ptr_q    <= '0;
              end
            end else begin
              state_q  <= SEARCH;
              bc_cnt_q <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (boundary) begin
            if (sr_d == COMMA) begin
              ptr_q <= '0;
            end else if (sr_d != IDLE) begin
              byte_out_q   <= sr_d;
              lane_id_q    <= ptr_q;
              byte_valid_q <= 1'b1;
              ptr_q        <= ptr_q + 2'd1;
            end
          end
        end
        default: begin
          state_q <= SEARCH;
        end
      endcase
    end
  end

  assign active     = active_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign lane_id    = lane_id_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: sync, delivery, lane rotation,
// lock loss, and asynchronous reset behaviour.
module tb_phy_rx_sync_ctrl;

  logic       clk_32f;
  logic       default_values;
  logic       data_in;
  logic       active;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [1:0] lane_id;
  logic [1:0] state_out;

  logic       active1;
  logic [7:0] byte_out1;
  logic       byte_valid1;
  logic [1:0] lane_id1;
  logic [1:0] state_out1;

  int n_checks = 0;
  int n_fail   = 0;

  phy_rx_sync_ctrl dut (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .data_in        (data_in),
    .active         (active),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .lane_id        (lane_id),
    .state_out      (state_out)
  );

  phy_rx_sync_ctrl #(.SYNC_COUNT(1)) dut1 (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .data_in        (data_in),
    .active         (active1),
    .byte_out       (byte_out1),
    .byte_valid     (byte_valid1),
    .lane_id        (lane_id1),
    .state_out      (state_out1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Shifts one byte MSB first; vo/ae collect byte_valid/active over bits 1..7,
  // vl is byte_valid just after the 8th bit edge.
  task automatic send_byte(input logic [7:0] b, output logic vo, output logic vl,
                           output logic ae);
    vo = 1'b0;
    ae = 1'b0;
    vl = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      data_in = b[7-i];
      @(posedge clk_32f);
      #1;
      if (i < 7) begin
        vo = vo | byte_valid;
        ae = ae | active;
      end else begin
        vl = byte_valid;
      end
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic pulse_reset();
    data_in = 1'b0;
    default_values = 1'b0;
    #2;
    default_values = 1'b1;
  endtask

  logic       vo, vl, ae;
  logic [7:0] dbytes [8];
  logic [1:0] dlanes [8];
  logic [7:0] mbytes [5];
  logic       mvld   [5];
  logic [1:0] mlanes [5];

  initial begin
    dbytes = '{8'hFF, 8'hDD, 8'hEE, 8'hCC, 8'hBB, 8'h99, 8'hAA, 8'h88};
    dlanes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    mbytes = '{8'hFF, 8'h7C, 8'hDD, 8'hBC, 8'hEE};
    mvld   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    mlanes = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};

    default_values = 1'b0;
    data_in = 1'b0;
    @(posedge clk_32f);
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'h00);
    chk("rst_lane", 32'(lane_id), 32'd0);
    default_values = 1'b1;

    // Four commas: LOCK after the first, ACTIVE on the 32nd bit
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(8'hBC, vo, vl, ae);
      chk("sync_novalid", 32'(vo | vl), 32'd0);
      chk("sync_active_early", 32'(ae), 32'd0);
      chk("sync_state", 32'(state_out), (k < 3) ? 32'd1 : 32'd2);
      chk("sync_active", 32'(active), (k < 3) ? 32'd0 : 32'd1);
      chk("sc1_active", 32'(active1), 32'd1);
      chk("sc1_state", 32'(state_out1), 32'd2);
      chk("sc1_novalid", 32'(byte_valid1), 32'd0);
    end

    // Eight data bytes after six commas rotate across lanes 0..3 twice
    pulse_reset();
    for (int unsigned k = 0; k < 6; k++) send_byte(8'hBC, vo, vl, ae);
    chk("d_active", 32'(active), 32'd1);
    for (int unsigned k = 0; k < 8; k++) begin
      send_byte(dbytes[k], vo, vl, ae);
      chk("d_strobe", 32'(vl), 32'd1);
      chk("d_pulse_width", 32'(vo), 32'd0);
      chk("d_byte", 32'(byte_out), 32'(dbytes[k]));
      chk("d_lane", 32'(lane_id), 32'(dlanes[k]));
    end
    send_byte(8'h7C, vo, vl, ae);
    chk("idle_nostrobe", 32'(vo | vl), 32'd0);
    chk("hold_byte", 32'(byte_out), 32'h88);
    chk("hold_lane", 32'(lane_id), 32'd3);

    // Idle keeps the pointer, comma resets it
    for (int unsigned k = 0; k < 5; k++) begin
      send_byte(mbytes[k], vo, vl, ae);
      chk("mix_strobe", 32'(vl), 32'(mvld[k]));
      chk("mix_pulse_width", 32'(vo), 32'd0);
      chk("mix_byte", 32'(byte_out), (k == 1) ? 32'hFF : (k == 3) ? 32'hDD : 32'(mbytes[k]));
      chk("mix_lane", 32'(lane_id), 32'(mlanes[k]));
    end

    // A non-comma during LOCK returns to SEARCH
    pulse_reset();
    send_byte(8'hBC, vo, vl, ae);
    send_byte(8'hBC, vo, vl, ae);
    chk("ll_lock", 32'(state_out), 32'd1);
    send_byte(8'h55, vo, vl, ae);
    chk("ll_search", 32'(state_out), 32'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(8'hBC, vo, vl, ae);
      chk("ll_state", 32'(state_out), (k < 3) ? 32'd1 : 32'd2);
      chk("ll_active", 32'(active), (k < 3) ? 32'd0 : 32'd1);
    end

    // Bit-shifted comma after three garbage bits
    pulse_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int unsigned k = 0; k < 4; k++) send_byte(8'hBC, vo, vl, ae);
    chk("shift_active", 32'(active), 32'd1);
    send_byte(8'h11, vo, vl, ae);
    chk("shift_strobe", 32'(vl), 32'd1);
    chk("shift_byte", 32'(byte_out), 32'h11);
    chk("shift_lane", 32'(lane_id), 32'd0);

    // Reset while the strobe is high
    default_values = 1'b0;
    #1;
    chk("rst_strobe_valid", 32'(byte_valid), 32'd0);
    chk("rst_strobe_active", 32'(active), 32'd0);
    chk("rst_strobe_state", 32'(state_out), 32'd0);
    default_values = 1'b1;

    // Reset three bits into a data byte, then resync
    for (int unsigned k = 0; k < 4; k++) send_byte(8'hBC, vo, vl, ae);
    chk("mid_pre_active", 32'(active), 32'd1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    default_values = 1'b0;
    #1;
    chk("mid_active", 32'(active), 32'd0);
    chk("mid_valid", 32'(byte_valid), 32'd0);
    chk("mid_state", 32'(state_out), 32'd0);
    chk("mid_byte", 32'(byte_out), 32'h00);
    chk("mid_lane", 32'(lane_id), 32'd0);
    default_values = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      send_byte(8'hBC, vo, vl, ae);
      chk("resync_novalid", 32'(vo | vl), 32'd0);
    end
    chk("resync_active", 32'(active), 32'd1);
    send_byte(8'h33, vo, vl, ae);
    chk("resync_strobe", 32'(vl), 32'd1);
    chk("resync_byte", 32'(byte_out), 32'h33);
    chk("resync_lane", 32'(lane_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
